// File: rtl/coproc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : coproc_sequencer
// Purpose  : Sequences one 5x5 matrix operation. Issues A/B bank read
//            addresses, computes each 9-bit result on a shared arithmetic
//            path, buffers all 25 results, then streams them as one
//            contiguous 25-cycle burst.
// Ports    : clk, reset (async, active-high)
//            start/opcode      - operation request, sampled in IDLE
//            a_addr/b_addr     - operand bank read addresses (row-major)
//            a_data/b_data     - operand read data, one cycle after address
//            busy              - operation in progress
//            res_valid/res_data- result burst
//            done              - one-cycle completion pulse
//            err               - illegal opcode flag (sticky until next start)
// Revision : 1.0 - initial release
// ============================================================================
module coproc_sequencer #(
    parameter int N  = 5,
    parameter int DW = 8,
    parameter int RW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    opcode,
    output logic [4:0]    a_addr,
    output logic [4:0]    b_addr,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic          busy,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);
    localparam logic [4:0] LAST_E   = 5'(N * N - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SCAL  = 3'b011;
    localparam logic [2:0] OP_TRANS = 3'b100;
    localparam logic [2:0] OP_NEG   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPUTE = 3'd1,
        S_DRAIN   = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_next;

    logic [2:0]          op;
    logic [2:0]          row, col, m;
    logic [2:0]          row_n, col_n, m_n;
    logic                step_elem;
    logic                last_issue;
    logic                issue_v;     // read data for (e_d, m_d) is on a_data/b_data
    logic [4:0]          e_d;
    logic [2:0]          m_d;
    logic [4:0]          sidx;
    logic signed [18:0]  acc;
    logic signed [18:0]  acc_sum;
    logic signed [7:0]   a_s, b_s;
    logic signed [15:0]  prod;
    logic signed [18:0]  prod19;
    logic [8:0]          a9, b9;
    logic [RW-1:0]       result;
    logic                wr_en;
    logic [RW-1:0]       cbuf [0:N*N-1];

    function automatic logic [4:0] lin(input logic [2:0] r, input logic [2:0] c);
        return 5'(r) * 5'd5 + 5'(c);
    endfunction

    function automatic logic [4:0] addr_a(input logic [2:0] o, input logic [2:0] r,
                                          input logic [2:0] c, input logic [2:0] mm);
        case (o)
            OP_MUL:   return lin(r, mm);
            OP_TRANS: return lin(c, r);
            default:  return lin(r, c);
        endcase
    endfunction

    function automatic logic [4:0] addr_b(input logic [2:0] o, input logic [2:0] r,
                                          input logic [2:0] c, input logic [2:0] mm);
        case (o)
            OP_MUL:  return lin(mm, c);
            OP_SCAL: return 5'd0;
            default: return lin(r, c);
        endcase
    endfunction

    function automatic logic [8:0] sat9(input logic signed [18:0] x);
        if (x > 19'sd255)
            return 9'h0ff;
        else if (x < -19'sd256)
            return 9'h100;
        else
            return x[8:0];
    endfunction

    // Issue counters: product walks m fastest, elementwise ops advance col every cycle.
    always_comb begin
        m_n   = m;
        col_n = col;
        row_n = row;
        step_elem = (op != OP_MUL) || (m == LAST_IDX);
        if (op == OP_MUL)
            m_n = (m == LAST_IDX) ? 3'd0 : m + 3'd1;
        if (step_elem) begin
            if (col == LAST_IDX) begin
                col_n = 3'd0;
                row_n = row + 3'd1;
            end else begin
                col_n = col + 3'd1;
            end
        end
        last_issue = (row == LAST_IDX) && (col == LAST_IDX) && step_elem;
    end

    // Shared arithmetic path on the returned operands.
    assign a_s     = a_data;
    assign b_s     = b_data;
    assign prod    = a_s * b_s;
    assign prod19  = {{3{prod[15]}}, prod};
    assign a9      = {a_data[7], a_data};
    assign b9      = {b_data[7], b_data};
    assign acc_sum = ((m_d == 3'd0) ? 19'sd0 : acc) + prod19;

    always_comb begin
        result = a9;
        case (op)
            OP_ADD:   result = a9 + b9;
            OP_SUB:   result = a9 - b9;
            OP_MUL:   result = sat9(acc_sum);
            OP_SCAL:  result = sat9(prod19);
            OP_TRANS: result = a9;
            OP_NEG:   result = 9'd0 - a9;
            default:  result = a9;
        endcase
    end

    assign wr_en = issue_v && ((op != OP_MUL) || (m_d == LAST_IDX));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next state and decoded outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = (opcode[2] & opcode[1]) ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (last_issue)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy       = 1'b1;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_data  = cbuf[sidx];
                if (sidx == LAST_E)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sequencing datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op      <= 3'd0;
            err     <= 1'b0;
            row     <= 3'd0;
            col     <= 3'd0;
            m       <= 3'd0;
            a_addr  <= 5'd0;
            b_addr  <= 5'd0;
            issue_v <= 1'b0;
            e_d     <= 5'd0;
            m_d     <= 3'd0;
            acc     <= 19'sd0;
            sidx    <= 5'd0;
        end else begin
            issue_v <= (state == S_COMPUTE);
            e_d     <= lin(row, col);
            m_d     <= m;
            if (issue_v)
                acc <= acc_sum;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op  <= opcode;
                        err <= opcode[2] & opcode[1];
                        if (!(opcode[2] & opcode[1])) begin
                            // First issue is index 0 for every legal opcode.
                            row    <= 3'd0;
                            col    <= 3'd0;
                            m      <= 3'd0;
                            a_addr <= 5'd0;
                            b_addr <= 5'd0;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!last_issue) begin
                        row    <= row_n;
                        col    <= col_n;
                        m      <= m_n;
                        a_addr <= addr_a(op, row_n, col_n, m_n);
                        b_addr <= addr_b(op, row_n, col_n, m_n);
                    end
                end
                S_DRAIN:  sidx <= 5'd0;
                S_STREAM: sidx <= sidx + 5'd1;
                default: ;
            endcase
        end
    end

    // Result buffer; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            cbuf[e_d] <= result;
    end

endmodule
`default_nettype wire

// File: tb/tb_coproc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coproc_sequencer
// Purpose  : Self-checking bench for coproc_sequencer. Operand banks are
//            modelled as synchronous-read memories; a table of operations
//            with hand-computed results is applied, followed by directed
//            sequences for illegal opcode, mid-operation reset and a start
//            pulse during the result burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coproc_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [4:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       busy, res_valid, done, err;
    logic [8:0] res_data;

    logic [7:0] amem [25];
    logic [7:0] bmem [25];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]        op;
        logic [24:0][7:0]  a;
        logic [24:0][7:0]  b;
        logic [24:0][8:0]  c;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    coproc_sequencer #(.N(5), .DW(8), .RW(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_data    (a_data),
        .b_data    (b_data),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_data <= amem[a_addr];
        b_data <= bmem[b_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int v);
        for (int k = 0; k < 25; k++) begin
            amem[k] = vecs[v].a[k];
            bmem[k] = vecs[v].b[k];
        end
    endtask

    // Runs one table entry cycle by cycle; cycle c is the c-th cycle after edge S.
    task automatic run_vec(input int v, input bit pulse_in_stream);
        int lat, nissue, e, mm, k;
        logic [2:0] op;
        logic [4:0] ea, eb;
        logic       ev;
        op     = vecs[v].op;
        lat    = (op == 3'b010) ? 152 : 52;
        nissue = (op == 3'b010) ? 125 : 25;
        load(v);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = 3'b110;   // must be ignored while busy
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (pulse_in_stream && c == lat - 10) start = 1'b1;
            if (pulse_in_stream && c == lat - 9)  start = 1'b0;
            ev = (c >= lat - 25) && (c < lat);
            check($sformatf("ctl op%0d c%0d {busy,valid,done}", op, c),
                  {29'd0, busy, res_valid, done},
                  {29'd0, (c < lat), ev, (c == lat)});
            if (c == 1)
                check($sformatf("err op%0d", op), {31'd0, err}, 32'd0);
            if (ev)
                check($sformatf("data op%0d idx%0d", op, c - (lat - 25)),
                      {23'd0, res_data}, {23'd0, vecs[v].c[c - (lat - 25)]});
            if (c <= nissue) begin
                if (op == 3'b010) begin
                    e  = (c - 1) / 5;
                    mm = (c - 1) % 5;
                    ea = 5'(5 * (e / 5) + mm);
                    eb = 5'(5 * mm + (e % 5));
                end else begin
                    k  = c - 1;
                    ea = (op == 3'b100) ? 5'(5 * (k % 5) + k / 5) : 5'(k);
                    eb = (op == 3'b011) ? 5'd0 : 5'(k);
                end
                check($sformatf("addr op%0d c%0d {a,b}", op, c),
                      {22'd0, a_addr, b_addr}, {22'd0, ea, eb});
            end
        end
        @(negedge clk);
        check($sformatf("idle after op%0d {busy,valid,done}", op),
              {29'd0, busy, res_valid, done}, 32'd0);
    endtask

    initial begin
        // ---------------- vector table ----------------
        for (int k = 0; k < 25; k++) begin
            vecs[0].op = 3'b000; vecs[0].a[k] = 8'(k);   vecs[0].b[k] = 8'(2 * k);
            vecs[0].c[k] = 9'(3 * k);
            vecs[1].op = 3'b001; vecs[1].a[k] = 8'h80;   vecs[1].b[k] = 8'h7f;
            vecs[1].c[k] = 9'h101;
            vecs[2].op = 3'b101; vecs[2].a[k] = 8'h80;   vecs[2].b[k] = 8'(k);
            vecs[2].c[k] = 9'h080;
            vecs[3].op = 3'b010; vecs[3].a[k] = (k / 5 == k % 5) ? 8'd1 : 8'd0;
            vecs[3].b[k] = 8'(k); vecs[3].c[k] = 9'(k);
            vecs[4].op = 3'b010; vecs[4].a[k] = 8'd127;  vecs[4].b[k] = 8'd127;
            vecs[4].c[k] = 9'h0ff;
            vecs[5].op = 3'b100; vecs[5].a[k] = 8'(k);   vecs[5].b[k] = 8'd9;
            vecs[5].c[k] = 9'(5 * (k % 5) + k / 5);
            vecs[6].op = 3'b011; vecs[6].a[k] = 8'd100;
            vecs[6].b[k] = (k == 0) ? 8'hfd : 8'd7;
            vecs[6].c[k] = 9'h100;
            vecs[7].op = 3'b011; vecs[7].a[k] = 8'(k - 12);
            vecs[7].b[k] = (k == 0) ? 8'd2 : 8'hff;
            vecs[7].c[k] = 9'(2 * (k - 12));
        end
        for (int k = 0; k < 25; k++) begin
            amem[k] = 8'd0;
            bmem[k] = 8'd0;
        end

        // ---------------- reset state ----------------
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 3'b000;
        repeat (3) @(negedge clk);
        check("reset {busy,valid,done,err}", {28'd0, busy, res_valid, done, err}, 32'd0);
        check("reset {a_addr,b_addr,res_data}", {13'd0, a_addr, b_addr, res_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- table-driven operations ----------------
        for (int v = 0; v < NV; v++)
            run_vec(v, 1'b0);

        // ---------------- illegal opcode ----------------
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'b111;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("illegal S+1 {busy,valid,done,err}", {28'd0, busy, res_valid, done, err}, 32'h3);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("illegal S+%0d {busy,valid,done,err}", c),
                  {28'd0, busy, res_valid, done, err}, 32'h1);
        end
        // next legal start clears err (checked at c=1 inside run_vec)
        run_vec(0, 1'b0);
        check("err after legal op", {31'd0, err}, 32'd0);

        // ---------------- reset during a product ----------------
        load(4);
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'b010;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset {busy,valid,done,err}", {28'd0, busy, res_valid, done, err}, 32'd0);
        check("async reset {a_addr,b_addr,res_data}", {13'd0, a_addr, b_addr, res_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post-reset no done", {30'd0, busy, done}, 32'd0);
        end

        // ---------------- normal run with start pulsed during STREAM ----------------
        run_vec(5, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no restart after stream pulse", {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
